dma_burst_fifo: RTL

Parametrised synchronous FIFO for the DMA datapath that buffers words between the memory-read and memory-write engines. It is generalised in data width, depth and almost-full threshold. Built-in burst tracking pulses `push_finish` when a programmed burst has been fully written and `pop_finish` when the same burst has been fully drained. The DMA controller uses those pulses to sequence descriptors.

---
 rtl/dma_pkg.sv | 16 +
 rtl/dma_burst_tracker.sv | 93 +++++++++
 rtl/dma_burst_fifo.sv | 78 +++++++
 3 files changed

// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA datapath blocks.
package dma_pkg;

   localparam int unsigned MEM_DATA_WIDTH = 32;
   localparam int unsigned BURST_LEN_W    = 4;

   typedef logic [BURST_LEN_W-1:0] burst_len_t;

   typedef enum logic [1:0] {
      StIdle,
      StActive,
      StPushDone,
      StPopDone
   } burst_state_e;

endpackage

// File: rtl/dma_burst_tracker.sv
// Burst tracker: counts accepted pushes/pops of one programmed burst and pulses
// push_finish / pop_finish the cycle after the final word on each side.
module dma_burst_tracker
   import dma_pkg::*;
#(
   parameter int unsigned LEN_W = BURST_LEN_W
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             flush,
   input  logic             wr_en,
   input  logic             rd_en,
   input  logic             burst_start,
   input  logic [LEN_W-1:0] burst_len,
   output logic             busy,
   output logic             push_finish,
   output logic             pop_finish
);

   burst_state_e     state;
   logic [LEN_W-1:0] len;
   logic [LEN_W-1:0] push_cnt;
   logic [LEN_W-1:0] pop_cnt;
   logic [LEN_W-1:0] push_nxt;
   logic [LEN_W-1:0] pop_nxt;
   logic             push_hit;
   logic             pop_hit;

   always_comb begin
      push_nxt = push_cnt + LEN_W'(wr_en);
      pop_nxt  = pop_cnt + LEN_W'(rd_en);
      push_hit = (push_nxt == len);
      pop_hit  = (pop_nxt == len);
   end

   assign busy = (state != StIdle);

   always_ff @(posedge clk) begin
      if (!rstn || flush) begin
         state       <= StIdle;
         len         <= '0;
         push_cnt    <= '0;
         pop_cnt     <= '0;
         push_finish <= 1'b0;
         pop_finish  <= 1'b0;
      end else begin
         push_finish <= 1'b0;
         pop_finish  <= 1'b0;
         case (state)
            StIdle: begin
               if (burst_start && (burst_len != '0)) begin
                  len      <= burst_len;
                  push_cnt <= '0;
                  pop_cnt  <= '0;
                  state    <= StActive;
               end
            end
            StActive: begin
               push_cnt <= push_nxt;
               pop_cnt  <= pop_nxt;
               if (push_hit && pop_hit) begin
                  push_finish <= 1'b1;
                  pop_finish  <= 1'b1;
                  state       <= StIdle;
               end else if (push_hit) begin
                  push_finish <= 1'b1;
                  state       <= StPushDone;
               end else if (pop_hit) begin
                  // Only reachable when words predating the burst are drained
                  pop_finish <= 1'b1;
                  state      <= StPopDone;
               end
            end
            StPushDone: begin
               pop_cnt <= pop_nxt;
               if (pop_hit) begin
                  pop_finish <= 1'b1;
                  state      <= StIdle;
               end
            end
            StPopDone: begin
               push_cnt <= push_nxt;
               if (push_hit) begin
                  push_finish <= 1'b1;
                  state       <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: rtl/dma_burst_fifo.sv
// First-word-fall-through FIFO between DMA read and write engines, with
// burst completion tracking for descriptor sequencing.
module dma_burst_fifo
   import dma_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = MEM_DATA_WIDTH,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned LEN_W      = BURST_LEN_W,
   parameter int unsigned AFULL_TH   = DEPTH - 4
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    flush,
   input  logic                    push,
   input  logic [DATA_WIDTH-1:0]   push_data,
   input  logic                    pop,
   output logic [DATA_WIDTH-1:0]   pop_data,
   output logic                    full,
   output logic                    empty,
   output logic                    almost_full,
   output logic [$clog2(DEPTH):0]  count,
   input  logic                    burst_start,
   input  logic [LEN_W-1:0]        burst_len,
   output logic                    busy,
   output logic                    push_finish,
   output logic                    pop_finish
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic                  wr_en;
   logic                  rd_en;

   // Extra MSB on each pointer distinguishes full from empty
   assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty       = (wr_ptr == rd_ptr);
   assign count       = wr_ptr - rd_ptr;
   assign almost_full = (count >= PW'(AFULL_TH));

   assign wr_en = push & ~full & ~flush;
   assign rd_en = pop & ~empty & ~flush;

   assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!rstn || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   dma_burst_tracker #(
      .LEN_W(LEN_W)
   ) u_tracker (
      .clk        (clk),
      .rstn       (rstn),
      .flush      (flush),
      .wr_en      (wr_en),
      .rd_en      (rd_en),
      .burst_start(burst_start),
      .burst_len  (burst_len),
      .busy       (busy),
      .push_finish(push_finish),
      .pop_finish (pop_finish)
   );

endmodule
